avmm_pio_sequencer: RTL

- Avalon-MM master (initiator) that drives an 8-bit output PIO slave (s1: address/chipselect/write_n/writedata/readdata, zero wait states) from fabric logic, with no CPU involvement.
- On a programmable tick it computes the next LED pattern (chaser or binary counter), writes it to PIO offset 0, and optionally reads it back and checks it.
- Sits beside the Nios in the td3 system as a hardware test and heartbeat source for the PIO data register.

---
 rtl/avmm_pio_sequencer.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/avmm_pio_sequencer.sv
// Avalon-MM master that writes a chaser/counter pattern to an output PIO on every prescaler tick.
// Optional write-readback check enabled by defining AVMM_PIO_SEQ_READBACK_EN.
module avmm_pio_sequencer #(
    parameter int TICK_DIV = 50000000,
    parameter int PIO_W    = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             mode,
    input  logic             err_clr,
    output logic [1:0]       avm_address,
    output logic             avm_chipselect,
    output logic             avm_write_n,
    output logic             avm_read,
    output logic [31:0]      avm_writedata,
    input  logic [31:0]      avm_readdata,
    input  logic             avm_waitrequest,
    output logic [PIO_W-1:0] pattern,
    output logic             busy,
    output logic             error,
    output logic             overrun
);

    localparam int CNT_W = $clog2(TICK_DIV);

    typedef enum logic [1:0] {S_IDLE, S_WR, S_RD, S_CHK} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               pending_q, pending_d;
    logic               overrun_q, overrun_d;
    logic [PIO_W-1:0]   pattern_q, pattern_d;
    logic [PIO_W-1:0]   next_q, next_d;
    logic               tick, consume, accept_wr, one_hot;
    logic [PIO_W-1:0]   next_calc;

    assign tick      = enable && (cnt_q == CNT_W'(TICK_DIV - 1));
    // A tick seen in IDLE starts the write immediately, giving the strobe one cycle after the tick.
    assign consume   = enable && (state_q == S_IDLE) && (pending_q || tick);
    assign accept_wr = (state_q == S_WR) && !avm_waitrequest;
    assign one_hot   = (pattern_q != '0) && ((pattern_q & (pattern_q - 1'b1)) == '0);

    always_comb begin
        if (mode)
            next_calc = pattern_q + 1'b1;
        else if (one_hot)
            next_calc = {pattern_q[PIO_W-2:0], pattern_q[PIO_W-1]};
        else
            next_calc = PIO_W'(1);
    end

    always_comb begin
        cnt_d     = (!enable || tick) ? '0 : cnt_q + 1'b1;
        pending_d = pending_q;
        if (!enable || consume)
            pending_d = 1'b0;
        else if (tick)
            pending_d = 1'b1;
        overrun_d = overrun_q;
        if (tick && pending_q)
            overrun_d = 1'b1;
        else if (err_clr)
            overrun_d = 1'b0;
        pattern_d = accept_wr ? next_q : pattern_q;
        next_d    = consume ? next_calc : next_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (consume) state_d = S_WR;
`ifdef AVMM_PIO_SEQ_READBACK_EN
            S_WR:   if (!avm_waitrequest) state_d = S_RD;
            S_RD:   if (!avm_waitrequest) state_d = S_CHK;
            S_CHK:  state_d = S_IDLE;
`else
            S_WR:   if (!avm_waitrequest) state_d = S_IDLE;
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves it unassigned (no latches).
        avm_address    = 2'd0;
        avm_chipselect = 1'b0;
        avm_write_n    = 1'b1;
        avm_read       = 1'b0;
        avm_writedata  = '0;
        case (state_q)
            S_WR: begin
                avm_chipselect           = 1'b1;
                avm_write_n              = 1'b0;
                avm_writedata[PIO_W-1:0] = next_q;
            end
`ifdef AVMM_PIO_SEQ_READBACK_EN
            S_RD: begin
                avm_chipselect = 1'b1;
                avm_read       = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
            pattern_q <= '0;
            next_q    <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            pattern_q <= pattern_d;
            next_q    <= next_d;
        end
    end

`ifdef AVMM_PIO_SEQ_READBACK_EN
    logic [31:0] rdata_q, rdata_d;
    logic        error_q, error_d;
    logic        mismatch;

    assign mismatch = (rdata_q[PIO_W-1:0] != pattern_q) || ((rdata_q >> PIO_W) != '0);

    always_comb begin
        rdata_d = ((state_q == S_RD) && !avm_waitrequest) ? avm_readdata : rdata_q;
        error_d = error_q;
        if ((state_q == S_CHK) && mismatch)
            error_d = 1'b1;
        else if (err_clr)
            error_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata_q <= '0;
            error_q <= 1'b0;
        end else begin
            rdata_q <= rdata_d;
            error_q <= error_d;
        end
    end

    assign error = error_q;
`else
    logic unused_rdata;
    assign unused_rdata = ^avm_readdata;
    assign error        = 1'b0;
`endif

    assign pattern = pattern_q;
    assign overrun = overrun_q;
    assign busy    = (state_q != S_IDLE);

endmodule
